// File: rtl/ctrl_pkg.sv
// Shared RV32I control definitions: opcodes, ALU/immediate encodings and the
// decoded control bundle carried through the ID/EX register.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    alu_op_e    alu_ctrl;
    logic       alu_src;
    imm_sel_e   imm_src;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] br_funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ctrl_t;

  // alt selects SUB over ADD and SRA over SRL
  function automatic alu_op_e alu_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I control decoder: instruction word to ctrl_t, plus which
// source registers the instruction actually reads (for hazard detection).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl            = '0;
    ctrl.alu_ctrl   = ALU_ADD;
    ctrl.imm_src    = IMM_I;
    ctrl.result_src = RES_ALU;
    ctrl.rd         = instr[11:7];
    ctrl.rs1        = instr[19:15];
    ctrl.rs2        = instr[24:20];
    uses_rs1        = 1'b0;
    uses_rs2        = 1'b0;
    bad             = 1'b0;

    case (opcode)
      OP_R: begin
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_op(funct3, funct7[5]);
        bad = !((funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_I: begin
        uses_rs1       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
        bad = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
              ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OP_LOAD: begin
        uses_rs1        = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
        bad = funct3[2] || (funct3 == 3'b011);
      end
      OP_BRANCH: begin
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.imm_src   = IMM_B;
        ctrl.br_funct3 = funct3;
        case (funct3[2:1])
          2'b00:   ctrl.alu_ctrl = ALU_SUB;
          2'b10:   ctrl.alu_ctrl = ALU_SLT;
          2'b11:   ctrl.alu_ctrl = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.imm_src    = IMM_J;
      end
      OP_JALR: begin
        uses_rs1        = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
        bad = (funct3 != 3'b000);
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_PASSB;
        ctrl.imm_src   = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_U;
      end
      OP_SYSTEM: begin
        // only ecall/ebreak are supported; both are no-ops for control
        bad = !((instr[31:7] == 25'h0) || (instr[31:7] == 25'h0002000));
      end
      default: bad = 1'b1;
    endcase

    if (ctrl.rd == 5'd0) ctrl.reg_write = 1'b0;

    // undecodable words travel down the pipe as a side-effect-free bundle
    if (bad) begin
      ctrl.alu_ctrl   = ALU_ADD;
      ctrl.alu_src    = 1'b0;
      ctrl.imm_src    = IMM_I;
      ctrl.reg_write  = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.result_src = RES_ALU;
      ctrl.branch     = 1'b0;
      ctrl.jump       = 1'b0;
      ctrl.jalr       = 1'b0;
      ctrl.br_funct3  = 3'b000;
      ctrl.illegal    = 1'b1;
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode stage: registers decoded control into the ID/EX register with a
// valid/ready handshake, load-use stall, flush and a saturating stall counter.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     instr,
  input  logic [DATA_WIDTH-1:0]     pc,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [3:0]                alu_ctrl,
  output logic                      alu_src,
  output logic [2:0]                imm_src,
  output logic                      reg_write,
  output logic                      mem_write,
  output logic [1:0]                result_src,
  output logic                      branch,
  output logic                      jump,
  output logic                      jalr,
  output logic [2:0]                br_funct3,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic                      illegal,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  ctrl_t dec;
  ctrl_t q;
  logic  uses_rs1;
  logic  uses_rs2;
  logic  hazard;
  logic  accept;

  ctrl_decode u_decode (
    .instr    (instr[31:0]),
    .ctrl     (dec),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // a load sitting in ID/EX cannot forward to the instruction right behind it
  assign hazard = out_valid && (q.result_src == RES_MEM) && (q.rd != 5'd0) &&
                  ((uses_rs1 && (dec.rs1 == q.rd)) || (uses_rs2 && (dec.rs2 == q.rd)));

  assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      q         <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_pc    <= pc;
        q         <= dec;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (in_valid && hazard && !flush && (stall_cnt != {CNT_WIDTH{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign alu_ctrl   = q.alu_ctrl;
  assign alu_src    = q.alu_src;
  assign imm_src    = q.imm_src;
  assign reg_write  = q.reg_write;
  assign mem_write  = q.mem_write;
  assign result_src = q.result_src;
  assign branch     = q.branch;
  assign jump       = q.jump;
  assign jalr       = q.jalr;
  assign br_funct3  = q.br_funct3;
  assign rd         = REG_ADDR_WIDTH'(q.rd);
  assign rs1        = REG_ADDR_WIDTH'(q.rs1);
  assign rs2        = REG_ADDR_WIDTH'(q.rs2);
  assign illegal    = q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Testbench for decode_ctrl_pipe: directed plan steps followed by random
// traffic, all checked against an instruction-table reference model.
module tb_decode_ctrl_pipe;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, out_pc;
  logic [3:0]  alu_ctrl;
  logic        alu_src, reg_write, mem_write, branch, jump, jalr, illegal;
  logic [2:0]  imm_src, br_funct3;
  logic [1:0]  result_src;
  logic [4:0]  rd, rs1, rs2;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int alu, asrc, imm, rw, mw, res, br, jmp, jr;
  } entry_t;

  typedef struct {
    bit ill;
    int alu, asrc, imm, rw, mw, res, br, jmp, jr;
  } exp_t;

  entry_t      tbl[$];
  int          loadFirst;
  bit          mv;
  logic [31:0] mword, mpc;
  int          mstall;

  decode_ctrl_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .alu_ctrl(alu_ctrl),
    .alu_src(alu_src), .imm_src(imm_src), .reg_write(reg_write),
    .mem_write(mem_write), .result_src(result_src), .branch(branch),
    .jump(jump), .jalr(jalr), .br_funct3(br_funct3), .rd(rd), .rs1(rs1),
    .rs2(rs2), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  task automatic addEntry(input logic [31:0] mask, input logic [31:0] match,
                          input int alu, input int asrc, input int imm, input int rw,
                          input int mw, input int res, input int br, input int jmp,
                          input int jr);
    entry_t e;
    e.mask = mask; e.match = match; e.alu = alu; e.asrc = asrc; e.imm = imm;
    e.rw = rw; e.mw = mw; e.res = res; e.br = br; e.jmp = jmp; e.jr = jr;
    tbl.push_back(e);
  endtask

  // RV32I instruction list as mask/match patterns with their expected control
  task automatic buildTable();
    logic [31:0] rAlu[10] = '{32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033,
                              32'h4033, 32'h5033, 32'h40005033, 32'h6033, 32'h7033};
    int          rOp[10]  = '{0, 1, 7, 5, 6, 4, 8, 9, 3, 2};
    logic [31:0] iAlu[6]  = '{32'h13, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013};
    int          iOp[6]   = '{0, 5, 6, 4, 3, 2};
    logic [31:0] bMat[6]  = '{32'h63, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063};
    int          bOp[6]   = '{1, 1, 5, 5, 6, 6};
    for (int i = 0; i < 10; i++) addEntry(32'hFE00707F, rAlu[i], rOp[i], 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)  addEntry(32'h0000707F, iAlu[i], iOp[i], 1, 0, 1, 0, 0, 0, 0, 0);
    addEntry(32'hFE00707F, 32'h00001013, 7, 1, 0, 1, 0, 0, 0, 0, 0);
    addEntry(32'hFE00707F, 32'h00005013, 8, 1, 0, 1, 0, 0, 0, 0, 0);
    addEntry(32'hFE00707F, 32'h40005013, 9, 1, 0, 1, 0, 0, 0, 0, 0);
    loadFirst = tbl.size();
    addEntry(32'h0000707F, 32'h00000003, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    addEntry(32'h0000707F, 32'h00001003, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    addEntry(32'h0000707F, 32'h00002003, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    addEntry(32'h0000707F, 32'h00004003, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    addEntry(32'h0000707F, 32'h00005003, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    addEntry(32'h0000707F, 32'h00000023, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    addEntry(32'h0000707F, 32'h00001023, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    addEntry(32'h0000707F, 32'h00002023, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)  addEntry(32'h0000707F, bMat[i], bOp[i], 0, 2, 0, 0, 0, 1, 0, 0);
    addEntry(32'h0000007F, 32'h0000006F, 0, 0, 4, 1, 0, 2, 0, 1, 0);
    addEntry(32'h0000707F, 32'h00000067, 0, 1, 0, 1, 0, 2, 0, 1, 1);
    addEntry(32'h0000007F, 32'h00000037, 10, 1, 3, 1, 0, 0, 0, 0, 0);
    addEntry(32'h0000007F, 32'h00000017, 0, 1, 3, 1, 0, 0, 0, 0, 0);
    addEntry(32'hFFFFFFFF, 32'h00000073, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addEntry(32'hFFFFFFFF, 32'h00100073, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic exp_t refDecode(input logic [31:0] w);
    exp_t e;
    e = '{default: 0};
    e.ill = 1'b1;
    foreach (tbl[i]) begin
      if ((w & tbl[i].mask) == tbl[i].match) begin
        e.ill = 1'b0; e.alu = tbl[i].alu; e.asrc = tbl[i].asrc; e.imm = tbl[i].imm;
        e.rw = tbl[i].rw; e.mw = tbl[i].mw; e.res = tbl[i].res; e.br = tbl[i].br;
        e.jmp = tbl[i].jmp; e.jr = tbl[i].jr;
      end
    end
    if (w[11:7] == 5'd0) e.rw = 0;
    return e;
  endfunction

  function automatic bit modelHazard(input logic [31:0] w);
    exp_t e;
    bit   u1, u2;
    e = refDecode(mword);
    if (!mv || e.ill || (e.res != 1) || (mword[11:7] == 5'd0)) return 1'b0;
    u1 = (w[6:0] == 7'h33) || (w[6:0] == 7'h63) || (w[6:0] == 7'h23) ||
         (w[6:0] == 7'h13) || (w[6:0] == 7'h03) || (w[6:0] == 7'h67);
    u2 = (w[6:0] == 7'h33) || (w[6:0] == 7'h63) || (w[6:0] == 7'h23);
    return (u1 && (w[19:15] == mword[11:7])) || (u2 && (w[24:20] == mword[11:7]));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegistered();
    exp_t e;
    checkOutput("out_valid", 32'(out_valid), 32'(mv));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(mstall));
    if (mv) begin
      e = refDecode(mword);
      checkOutput("out_pc", out_pc, mpc);
      checkOutput("rd", 32'(rd), 32'(mword[11:7]));
      checkOutput("rs1", 32'(rs1), 32'(mword[19:15]));
      checkOutput("rs2", 32'(rs2), 32'(mword[24:20]));
      checkOutput("illegal", 32'(illegal), 32'(e.ill));
      checkOutput("reg_write", 32'(reg_write), 32'(e.rw));
      checkOutput("mem_write", 32'(mem_write), 32'(e.mw));
      checkOutput("branch", 32'(branch), 32'(e.br));
      checkOutput("jump", 32'(jump), 32'(e.jmp));
      if (!e.ill) begin
        checkOutput("alu_ctrl", 32'(alu_ctrl), 32'(e.alu));
        checkOutput("alu_src", 32'(alu_src), 32'(e.asrc));
        checkOutput("imm_src", 32'(imm_src), 32'(e.imm));
        checkOutput("result_src", 32'(result_src), 32'(e.res));
        checkOutput("jalr", 32'(jalr), 32'(e.jr));
        if (e.br != 0) checkOutput("br_funct3", 32'(br_funct3), 32'(mword[14:12]));
      end
    end
  endtask

  // one cycle: drive at negedge, check in_ready, advance model at posedge, check at next negedge
  task automatic applyStimulus(input bit v, input logic [31:0] w, input logic [31:0] p,
                               input bit fl, input bit ordy);
    bit hz, rdy;
    in_valid = v; instr = w; pc = p; flush = fl; out_ready = ordy;
    #1;
    hz  = modelHazard(w);
    rdy = !fl && !hz && (!mv || ordy);
    checkOutput("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    if (v && hz && !fl && (mstall < 65535)) mstall++;
    if (fl) mv = 1'b0;
    else if (v && rdy) begin
      mv = 1'b1; mword = w; mpc = p;
    end else if (ordy) mv = 1'b0;
    @(negedge clk);
    checkRegistered();
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    int          k;
    if ($urandom_range(0, 9) == 0) return $urandom;
    if ($urandom_range(0, 3) == 0) k = loadFirst + $urandom_range(0, 4);
    else k = $urandom_range(0, tbl.size() - 1);
    w = tbl[k].match | ($urandom & ~tbl[k].mask);
    if (tbl[k].mask != 32'hFFFFFFFF) begin
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
    end
    return w;
  endfunction

  initial begin
    buildTable();
    mv = 1'b0; mword = '0; mpc = '0; mstall = 0;

    rst = 1'b1; in_valid = 1'b1; instr = 32'h002081B3; pc = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst_rd", 32'(rd), 32'd0);
    rst = 1'b0;

    applyStimulus(1, 32'h002081B3, 32'h100, 0, 1);
    checkOutput("add_valid", 32'(out_valid), 32'd1);
    checkOutput("add_alu", 32'(alu_ctrl), 32'd0);
    checkOutput("add_rd", 32'(rd), 32'd3);
    checkOutput("add_rs1", 32'(rs1), 32'd1);
    checkOutput("add_rs2", 32'(rs2), 32'd2);
    checkOutput("add_rw", 32'(reg_write), 32'd1);
    checkOutput("add_res", 32'(result_src), 32'd0);

    applyStimulus(1, 32'h40208133, 32'h104, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h00000013, 32'h108, 0, 0);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_alu", 32'(alu_ctrl), 32'd1);
      checkOutput("hold_pc", out_pc, 32'h104);
    end
    applyStimulus(1, 32'h00000013, 32'h108, 0, 1);

    applyStimulus(1, 32'h0000A283, 32'h10C, 0, 1);
    applyStimulus(1, 32'h00528333, 32'h110, 0, 1);
    checkOutput("lu_bubble", 32'(out_valid), 32'd0);
    checkOutput("lu_stall", 32'(stall_cnt), 32'd1);
    applyStimulus(1, 32'h00528333, 32'h110, 0, 1);
    checkOutput("lu_emit_pc", out_pc, 32'h110);
    checkOutput("lu_emit_rd", 32'(rd), 32'd6);

    applyStimulus(1, 32'h0000A283, 32'h114, 0, 1);
    applyStimulus(1, 32'h00208333, 32'h118, 0, 1);
    checkOutput("nolu_valid", 32'(out_valid), 32'd1);
    checkOutput("nolu_pc", out_pc, 32'h118);
    checkOutput("nolu_stall", 32'(stall_cnt), 32'd1);

    applyStimulus(1, 32'h00208463, 32'h11C, 0, 1);
    checkOutput("beq_branch", 32'(branch), 32'd1);
    checkOutput("beq_f3", 32'(br_funct3), 32'd0);
    checkOutput("beq_imm", 32'(imm_src), 32'd2);
    applyStimulus(1, 32'h00300193, 32'h120, 1, 1);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    applyStimulus(0, 32'h00300193, 32'h120, 0, 1);
    checkOutput("flush_dropped", 32'(out_valid), 32'd0);

    applyStimulus(1, 32'hFFFFFFFF, 32'h124, 0, 1);
    checkOutput("ill_flag", 32'(illegal), 32'd1);
    checkOutput("ill_valid", 32'(out_valid), 32'd1);
    checkOutput("ill_rw", 32'(reg_write), 32'd0);
    checkOutput("ill_mw", 32'(mem_write), 32'd0);
    applyStimulus(1, 32'h00100013, 32'h128, 0, 1);
    checkOutput("x0_rw", 32'(reg_write), 32'd0);
    checkOutput("x0_ill", 32'(illegal), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom & 32'hFFFFFFFC,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    end

    $display("[TB] directed and random phases complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
